// File: rtl/uart_cmd_decoder.sv
// Assembles channel + 32-bit little-endian command packets into per-channel div/steps/dir registers.
// Define CMD_CHECKSUM_EN to require a sixth XOR checksum byte per packet.
module uart_cmd_decoder #(
   parameter int unsigned NUM_CH         = 10,
   parameter int unsigned TIMEOUT_CYCLES = 262143
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   input  logic [NUM_CH-1:0]    active_in,
   output logic [NUM_CH*15-1:0] div_flat,
   output logic [NUM_CH*12-1:0] steps_flat,
   output logic [NUM_CH-1:0]    dir_out,
   output logic [NUM_CH-1:0]    pending,
   output logic [NUM_CH-1:0]    cmd_load,
   output logic                 cmd_drop,
   output logic                 status_req,
   output logic                 frame_err
);
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CMD_CHECKSUM_EN
   typedef enum logic [2:0] {StIdle, StB1, StB2, StB3, StB4, StChk} state_e;
`else
   typedef enum logic [2:0] {StIdle, StB1, StB2, StB3, StB4} state_e;
`endif

   state_e            state_q;
   logic [3:0]        ch_q;
   logic [31:0]       word_q;
   logic [CntW-1:0]   cnt_q;
   logic [NUM_CH-1:0] act_q;
`ifdef CMD_CHECKSUM_EN
   logic [7:0]        sum_q;
`endif

   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] pend_eff;
   logic [NUM_CH-1:0] load_vec;
   logic              fire;
   logic              sum_ok;
   logic              drop;
   logic [31:0]       word_full;
   logic              unused_word;

   always_comb begin
      rise     = active_in & ~act_q;
      // A consume edge in the completion cycle frees the channel before the accept decision.
      pend_eff = pending & ~rise;
`ifdef CMD_CHECKSUM_EN
      fire      = rx_valid && (state_q == StChk);
      sum_ok    = (rx_data == sum_q);
      word_full = word_q;
`else
      fire      = rx_valid && (state_q == StB4);
      sum_ok    = 1'b1;
      word_full = {rx_data, word_q[31:8]};
`endif
      load_vec = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         load_vec[c] = fire && sum_ok && (ch_q == 4'(c)) && !pend_eff[c];
      end
      drop = fire && !(|load_vec);
   end

   assign unused_word = ^word_full[3:0];

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         ch_q       <= '0;
         word_q     <= '0;
         cnt_q      <= '0;
         act_q      <= '0;
`ifdef CMD_CHECKSUM_EN
         sum_q      <= '0;
`endif
         div_flat   <= '0;
         steps_flat <= '0;
         dir_out    <= '0;
         pending    <= '0;
         cmd_load   <= '0;
         cmd_drop   <= 1'b0;
         status_req <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         act_q      <= active_in;
         cmd_load   <= load_vec;
         cmd_drop   <= drop;
         status_req <= 1'b0;
         frame_err  <= 1'b0;

         for (int c = 0; c < NUM_CH; c++) begin
            if (rise[c]) begin
               pending[c]             <= 1'b0;
               steps_flat[12*c +: 12] <= '0;
            end
            if (load_vec[c]) begin
               div_flat[15*c +: 15]   <= word_full[18:4];
               steps_flat[12*c +: 12] <= word_full[30:19];
               dir_out[c]             <= word_full[31];
               pending[c]             <= 1'b1;
            end
         end

         if (rx_valid) begin
            cnt_q <= CntW'(TIMEOUT_CYCLES);
         end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
         end

         if (rx_valid) begin
            unique case (state_q)
               StIdle: begin
                  if (rx_data[3:0] == 4'hF) begin
                     status_req <= 1'b1;
                  end else begin
                     ch_q    <= rx_data[3:0];
                     state_q <= StB1;
`ifdef CMD_CHECKSUM_EN
                     sum_q   <= rx_data;
`endif
                  end
               end
               StB1: begin
                  word_q  <= {rx_data, word_q[31:8]};
                  state_q <= StB2;
`ifdef CMD_CHECKSUM_EN
                  sum_q   <= sum_q ^ rx_data;
`endif
               end
               StB2: begin
                  word_q  <= {rx_data, word_q[31:8]};
                  state_q <= StB3;
`ifdef CMD_CHECKSUM_EN
                  sum_q   <= sum_q ^ rx_data;
`endif
               end
               StB3: begin
                  word_q  <= {rx_data, word_q[31:8]};
                  state_q <= StB4;
`ifdef CMD_CHECKSUM_EN
                  sum_q   <= sum_q ^ rx_data;
`endif
               end
               StB4: begin
                  word_q  <= {rx_data, word_q[31:8]};
`ifdef CMD_CHECKSUM_EN
                  sum_q   <= sum_q ^ rx_data;
                  state_q <= StChk;
`else
                  state_q <= StIdle;
`endif
               end
`ifdef CMD_CHECKSUM_EN
               StChk: state_q <= StIdle;
`endif
               default: state_q <= StIdle;
            endcase
         end else if ((state_q != StIdle) && (cnt_q == '0)) begin
            frame_err <= 1'b1;
            state_q   <= StIdle;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: random packets/status/consume/timeouts vs. an array model.
module tb_uart_cmd_decoder;
   localparam int NCH = 10;
   localparam int TMO = 40;
`ifdef CMD_CHECKSUM_EN
   localparam int PKT_N = 6;
`else
   localparam int PKT_N = 5;
`endif

   logic             CLK = 1'b0;
   logic             reset = 1'b1;
   logic             rx_valid = 1'b0;
   logic [7:0]       rx_data = '0;
   logic [NCH-1:0]   active_in = '0;
   logic [NCH*15-1:0] div_flat;
   logic [NCH*12-1:0] steps_flat;
   logic [NCH-1:0]   dir_out, pending, cmd_load;
   logic             cmd_drop, status_req, frame_err;

   always #5 CLK = ~CLK;

   uart_cmd_decoder #(.NUM_CH(NCH), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .active_in(active_in),
      .div_flat(div_flat), .steps_flat(steps_flat), .dir_out(dir_out), .pending(pending),
      .cmd_load(cmd_load), .cmd_drop(cmd_drop), .status_req(status_req), .frame_err(frame_err)
   );

   typedef struct {
      logic [NCH-1:0]    load;
      logic              drop, stat, ferr;
      logic [NCH*15-1:0] div;
      logic [NCH*12-1:0] steps;
      logic [NCH-1:0]    dir, pend;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  checks = 0;
   int  errors = 0;
   int  m_div[NCH], m_steps[NCH], m_dir[NCH], m_pend[NCH];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ev_t snap();
      ev_t e;
      e.load = '0; e.drop = 1'b0; e.stat = 1'b0; e.ferr = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         e.div[15*c +: 15]   = 15'(m_div[c]);
         e.steps[12*c +: 12] = 12'(m_steps[c]);
         e.dir[c]            = 1'(m_dir[c]);
         e.pend[c]           = 1'(m_pend[c]);
      end
      return e;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_div[c] = 0; m_steps[c] = 0; m_dir[c] = 0; m_pend[c] = 0;
      end
   endfunction

   function automatic void model_clear(input logic [NCH-1:0] m);
      for (int c = 0; c < NCH; c++) if (m[c]) begin m_pend[c] = 0; m_steps[c] = 0; end
   endfunction

   function automatic void model_complete(input int ch, input logic [31:0] w, input bit ok);
      ev_t e;
      if (ch < NCH && ok && m_pend[ch] == 0) begin
         m_div[ch]   = int'((w >> 4) & 32'h7FFF);
         m_steps[ch] = int'((w >> 19) & 32'hFFF);
         m_dir[ch]   = int'(w >> 31);
         m_pend[ch]  = 1;
         e = snap();
         e.load[ch] = 1'b1;
      end else begin
         e = snap();
         e.drop = 1'b1;
      end
      exp_q.push_back(e);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [31:0] w, input int rise_idx,
                           input logic [NCH-1:0] rmask, input bit gaps, input bit bad_sum);
      logic [7:0] by[6];
      bit ok;
      by[0] = b0;
      for (int i = 1; i <= 4; i++) by[i] = w[8*(i-1) +: 8];
      by[5] = by[0] ^ by[1] ^ by[2] ^ by[3] ^ by[4] ^ {7'd0, bad_sum};
`ifdef CMD_CHECKSUM_EN
      ok = !bad_sum;
`else
      ok = 1'b1;
`endif
      for (int i = 0; i < PKT_N; i++) begin
         if (i == rise_idx) begin active_in = rmask; model_clear(rmask); end
         if (i == PKT_N - 1) model_complete(int'(b0[3:0]), w, ok);
         rx_data = by[i]; rx_valid = 1'b1;
         tick();
         rx_valid = 1'b0; active_in = '0;
         if (gaps && i < PKT_N - 1) repeat ($urandom_range(0, 3)) tick();
      end
   endtask

   task automatic consume(input logic [NCH-1:0] m);
      active_in = m; model_clear(m);
      tick();
      active_in = '0;
      tick();
   endtask

   task automatic send_status(input logic [3:0] hi);
      ev_t e;
      e = snap(); e.stat = 1'b1;
      exp_q.push_back(e);
      send_byte({hi, 4'hF});
   endtask

   task automatic partial(input logic [7:0] b0, input int k);
      ev_t e;
      send_byte(b0);
      for (int i = 1; i < k; i++) send_byte(8'($urandom));
      e = snap(); e.ferr = 1'b1;
      exp_q.push_back(e);
      repeat (TMO + 5) tick();
   endtask

   task automatic check_regs(input string name);
      ev_t e;
      e = snap();
      @(negedge CLK);
      check({name, " pending"}, pending, e.pend);
      check({name, " steps"}, steps_flat, e.steps);
      check({name, " div"}, div_flat, e.div);
      check({name, " dir"}, dir_out, e.dir);
      @(posedge CLK);
      #1;
   endtask

   // Monitor: every strobe from the DUT must match the oldest expected event.
   initial begin
      forever begin
         @(negedge CLK);
         if (!reset && ((|cmd_load) || cmd_drop || status_req || frame_err)) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious: got load=%0h drop=%0b stat=%0b ferr=%0b expected none",
                        cmd_load, cmd_drop, status_req, frame_err);
            end else begin
               mon_e = exp_q.pop_front();
               check("cmd_load", cmd_load, mon_e.load);
               check("flags drop/stat/ferr", {cmd_drop, status_req, frame_err},
                     {mon_e.drop, mon_e.stat, mon_e.ferr});
               check("ev div", div_flat, mon_e.div);
               check("ev steps", steps_flat, mon_e.steps);
               check("ev dir", dir_out, mon_e.dir);
               check("ev pending", pending, mon_e.pend);
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, ch, ri;
      logic [7:0] b0;
      model_reset();
      @(negedge CLK);
      check("reset div", div_flat, '0);
      check("reset steps", steps_flat, '0);
      check("reset dir", dir_out, '0);
      check("reset pending", pending, '0);
      check("reset strobes", {cmd_load, cmd_drop, status_req, frame_err}, '0);
      @(posedge CLK);
      #1 reset = 1'b0;
      tick();

      send_pkt(8'h03, 32'h80280050, -1, '0, 1'b0, 1'b0);
      tick();
      check_regs("ch3 load");
      send_pkt(8'h03, 32'h12345678, -1, '0, 1'b1, 1'b0);
      tick();
      consume(NCH'(1) << 3);
      check_regs("ch3 consume");
      send_status(4'h1);
      send_pkt(8'h01, 32'hDEADBEEF, -1, '0, 1'b0, 1'b0);
      partial(8'h02, 2);
      send_pkt(8'h02, 32'h0F0F1234, -1, '0, 1'b1, 1'b0);
      send_pkt(8'h0C, 32'hFFFFFFFF, -1, '0, 1'b0, 1'b0);
      send_pkt(8'h05, 32'h11111111, -1, '0, 1'b0, 1'b0);
      send_pkt(8'h05, 32'hFEDCBA98, PKT_N - 1, NCH'(1) << 5, 1'b0, 1'b0);
      tick();
      check_regs("simultaneous");
`ifdef CMD_CHECKSUM_EN
      send_pkt(8'h06, 32'h80280050, -1, '0, 1'b0, 1'b1);
`endif
      // Reset mid-packet must discard the partial frame and every register.
      send_byte(8'h04);
      send_byte(8'h55);
      #2 reset = 1'b1;
      model_reset();
      check_regs("mid reset");
      reset = 1'b0;
      tick();
      send_pkt(8'hA4, 32'h80280050, -1, '0, 1'b0, 1'b0);

      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 99);
         if (r < 55) begin
            ch = ($urandom_range(0, 3) != 0) ? $urandom_range(0, NCH - 1) : $urandom_range(0, 14);
            b0 = {4'($urandom_range(0, 15)), 4'(ch)};
            ri = ($urandom_range(0, 2) == 0) ? $urandom_range(0, PKT_N - 1) : -1;
            send_pkt(b0, $urandom, ri, NCH'($urandom), 1'($urandom_range(0, 1)),
`ifdef CMD_CHECKSUM_EN
                     ($urandom_range(0, 5) == 0));
`else
                     1'b0);
`endif
         end else if (r < 75) begin
            consume(NCH'($urandom));
         end else if (r < 88) begin
            send_status(4'($urandom_range(0, 15)));
         end else if (r < 92) begin
            partial({4'($urandom_range(0, 15)), 4'($urandom_range(0, 14))},
                    $urandom_range(1, PKT_N - 1));
         end else begin
            tick();
            check_regs("random regs");
         end
         repeat ($urandom_range(0, 2)) tick();
      end

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      check("drain queue empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
